dragon_body_scheduler: RTL and testbench

Sequencing controller for the dragon body segment queue. It turns the frame-rate `vsync` into the movement counter the body queue samples, and arbitrates asynchronous heal and hit requests from game logic into single-cycle `states` pulses, at most one per frame. It also keeps a shadow segment count, hit invulnerability and game-over status. It sits between the game-event logic and the body segment queue, and drives that queue's `States` and `movement_counter` inputs directly.

---
 rtl/dragon_pkg.sv | 17 +
 rtl/dragon_body_scheduler_vsync.sv | 19 +
 rtl/dragon_body_scheduler.sv | 131 +++++++++++++
 tb/tb_dragon_body_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dragon_pkg.sv
// Shared definitions for the dragon body queue and its scheduler.
// Body command codes and scheduler FSM encodings.
package dragon_pkg;

  localparam logic [1:0] CMD_MOVE = 2'b00;
  localparam logic [1:0] CMD_HEAL = 2'b01;
  localparam logic [1:0] CMD_HIT  = 2'b10;
  localparam logic [1:0] CMD_IDLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GROW = 2'd1,
    ST_PLAY = 2'd2,
    ST_DEAD = 2'd3
  } sched_state_t;

endpackage

// File: rtl/dragon_body_scheduler_vsync.sv
// Rising-edge detector for the frame sync level.
// Shared by every block that advances once per frame.
module vsync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_tick
);

  logic pre_vsync;

  always_ff @(posedge clk) begin
    if (!reset) pre_vsync <= 1'b0;
    else        pre_vsync <= vsync;
  end

  assign frame_tick = vsync & ~pre_vsync;

endmodule

// File: rtl/dragon_body_scheduler.sv
// Frame sequencer for the dragon body queue: movement counter,
// heal/hit arbitration, shadow length, cooldown and game over.
module dragon_body_scheduler #(
  parameter int MOVE_PERIOD  = 10,
  parameter int HIT_COOLDOWN = 60,
  parameter int START_LEN    = 3,
  parameter int MAX_LEN      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       heal_req,
  input  logic       hit_req,
  output logic [1:0] states,
  output logic [5:0] movement_counter,
  output logic       move_tick,
  output logic [2:0] length,
  output logic       invulnerable,
  output logic       game_over
);
  import dragon_pkg::*;

  localparam logic [5:0] MOVE_TOP = 6'(MOVE_PERIOD);
  localparam logic [6:0] COOL_LD  = 7'(HIT_COOLDOWN);
  localparam logic [2:0] START_L  = 3'(START_LEN);
  localparam logic [2:0] MAX_L    = 3'(MAX_LEN);

  logic         frame_tick;
  sched_state_t state, state_nx;
  logic         heal_pend, heal_pend_nx;
  logic         hit_pend, hit_pend_nx;
  logic [6:0]   cool, cool_nx;
  logic [5:0]   cnt_nx;
  logic [2:0]   len_nx;
  logic [1:0]   cmd_nx;

  vsync_edge_detect u_edge (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    cmd_nx       = CMD_IDLE;
    len_nx       = length;
    cool_nx      = cool;
    cnt_nx       = movement_counter;
    heal_pend_nx = 1'b0;
    hit_pend_nx  = 1'b0;
    move_tick    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DEAD: begin
        if (start) state_nx = ST_GROW;
      end
      ST_GROW: begin
        if (length == START_L) begin
          state_nx = ST_PLAY;
        end else if (frame_tick) begin
          cmd_nx = CMD_HEAL;
          len_nx = length + 3'd1;
        end
      end
      ST_PLAY: begin
        heal_pend_nx = heal_pend;
        hit_pend_nx  = hit_pend;
        if (frame_tick) begin
          if (cool != 7'd0) cool_nx = cool - 7'd1;
          if (movement_counter == MOVE_TOP) begin
            cnt_nx    = 6'd0;
            move_tick = 1'b1;
          end else begin
            cnt_nx = movement_counter + 6'd1;
          end
          // hit wins; a waiting heal stays pending for the next frame
          if (hit_pend) begin
            hit_pend_nx = 1'b0;
            if (!invulnerable) begin
              cmd_nx  = CMD_HIT;
              len_nx  = length - 3'd1;
              cool_nx = COOL_LD;
              if (length == 3'd1) state_nx = ST_DEAD;
            end
          end else if (heal_pend) begin
            heal_pend_nx = 1'b0;
            if (length != MAX_L) begin
              cmd_nx = CMD_HEAL;
              len_nx = length + 3'd1;
            end
          end
        end
        heal_pend_nx = heal_pend_nx | heal_req;
        hit_pend_nx  = hit_pend_nx | hit_req;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (state_nx != ST_PLAY) begin
      cnt_nx  = 6'd0;
      cool_nx = 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      states           <= CMD_IDLE;
      movement_counter <= 6'd0;
      length           <= 3'd0;
      cool             <= 7'd0;
      heal_pend        <= 1'b0;
      hit_pend         <= 1'b0;
    end else begin
      states           <= cmd_nx;
      movement_counter <= cnt_nx;
      length           <= len_nx;
      cool             <= cool_nx;
      heal_pend        <= heal_pend_nx;
      hit_pend         <= hit_pend_nx;
    end
  end

  assign invulnerable = (cool != 7'd0);
  assign game_over    = (state == ST_DEAD);

endmodule

// File: tb/tb_dragon_body_scheduler.sv
// Random-stimulus bench for dragon_body_scheduler against
// a per-cycle behavioural model of the game rules.
module tb_dragon_body_scheduler;

  localparam int MP = 10;
  localparam int HC = 60;
  localparam int SL = 3;
  localparam int ML = 7;
  localparam int CYCLES = 20000;

  logic       clk = 1'b0;
  logic       reset, vsync, start, heal_req, hit_req;
  logic [1:0] states;
  logic [5:0] movement_counter;
  logic       move_tick;
  logic [2:0] length;
  logic       invulnerable, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  // mode: 0 idle, 1 growing, 2 playing, 3 dead
  int m_mode = 0, m_len = 0, m_cool = 0, m_cnt = 0, m_cmd = 3;
  bit m_heal = 0, m_hit = 0, m_prev_v = 0;
  int heals = 0, hits = 0, deaths = 0, moves = 0;

  always #5 clk = ~clk;

  dragon_body_scheduler #(
    .MOVE_PERIOD  (MP),
    .HIT_COOLDOWN (HC),
    .START_LEN    (SL),
    .MAX_LEN      (ML)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .vsync            (vsync),
    .start            (start),
    .heal_req         (heal_req),
    .hit_req          (hit_req),
    .states           (states),
    .movement_counter (movement_counter),
    .move_tick        (move_tick),
    .length           (length),
    .invulnerable     (invulnerable),
    .game_over        (game_over)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input bit st,
                            input bit hr, input bit kr);
    bit tick;
    int nm, nl, nc, nn, ns;
    bit nh, nk;
    if (!rst) begin
      m_mode = 0; m_len = 0; m_cool = 0; m_cnt = 0; m_cmd = 3;
      m_heal = 0; m_hit = 0; m_prev_v = 0;
      return;
    end
    tick = v && !m_prev_v;
    nm = m_mode; nl = m_len; nc = m_cool; nn = m_cnt; ns = 3;
    nh = 0; nk = 0;
    if (m_mode == 0 || m_mode == 3) begin
      if (st) nm = 1;
    end else if (m_mode == 1) begin
      if (m_len == SL) nm = 2;
      else if (tick) begin ns = 1; nl = m_len + 1; end
    end else begin
      nh = m_heal; nk = m_hit;
      if (tick) begin
        if (m_cool > 0) nc = m_cool - 1;
        nn = (m_cnt == MP) ? 0 : m_cnt + 1;
        if (m_hit) begin
          nk = 0;
          if (m_cool == 0) begin
            ns = 2; nl = m_len - 1; nc = HC;
            if (nl == 0) nm = 3;
          end
        end else if (m_heal) begin
          nh = 0;
          if (m_len < ML) begin ns = 1; nl = m_len + 1; end
        end
      end
      nh = nh | hr;
      nk = nk | kr;
    end
    if (nm != 2) begin nn = 0; nc = 0; end
    if (ns == 1) heals++;
    if (ns == 2) hits++;
    if (nm == 3 && m_mode != 3) deaths++;
    m_mode = nm; m_len = nl; m_cool = nc; m_cnt = nn; m_cmd = ns;
    m_heal = nh; m_hit = nk; m_prev_v = v;
  endtask

  initial begin
    int phase;
    bit exp_tick;
    reset = 1'b0; vsync = 1'b0; start = 1'b0;
    heal_req = 1'b0; hit_req = 1'b0;
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      phase = (c / 2500) % 4;
      reset = !(c < 2 || $urandom_range(0, 4999) == 0 ||
                (m_cmd == 1 && $urandom_range(0, 15) == 0));
      vsync = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 39) == 0);
      unique case (phase)
        0: begin
          hit_req  = ($urandom_range(0, 39) == 0);
          heal_req = ($urandom_range(0, 39) == 0);
        end
        1: begin
          hit_req  = ($urandom_range(0, 4) == 0);
          heal_req = 1'b0;
        end
        2: begin
          hit_req  = ($urandom_range(0, 299) == 0);
          heal_req = ($urandom_range(0, 2) == 0);
        end
        default: begin
          hit_req  = ($urandom_range(0, 9) == 0);
          heal_req = ($urandom_range(0, 9) == 0);
        end
      endcase
      #1;
      exp_tick = (m_mode == 2) && vsync && !m_prev_v && (m_cnt == MP);
      if (exp_tick && reset) moves++;
      if (c > 0) check("move_tick", move_tick, exp_tick);
      @(posedge clk);
      model_step(reset, vsync, start, heal_req, hit_req);
      #1;
      check("states", states, m_cmd);
      check("movement_counter", movement_counter, m_cnt);
      check("length", length, m_len);
      check("invulnerable", invulnerable, m_cool != 0);
      check("game_over", game_over, m_mode == 3);
    end
    $display("[TB] coverage: heals=%0d hits=%0d deaths=%0d moves=%0d",
             heals, hits, deaths, moves);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
